sram_ctrl: RTL
==============

Name: sram_ctrl

Overview:
Initiator-side controller that drives the single-port synchronous SRAM (one-cycle registered read, write-or-read per cycle). It turns a valid/ready command stream into SRAM port cycles and returns read data on a registered response channel with backpressure. It also includes a clear engine that writes CLEAR_VALUE to every cell, on request or after reset. It sits between client logic and the SRAM instance.

Parameters:
ADDR_WIDTH, 8, SRAM address width
DATA_WIDTH, 8, SRAM data width
DEPTH, 256, number of valid cells; 1 <= DEPTH <= 2**ADDR_WIDTH
CLEAR_VALUE, 0, DATA_WIDTH value written by the clear engine and returned for out-of-range reads
INIT_ON_RESET, 1, 1 = run a clear sequence automatically when reset deasserts

Ports:
i_clk  input  1  main clock
i_rst_n  input  1  asynchronous active-low reset
i_cmd_valid  input  1  command valid
o_cmd_ready  output  1  command accepted when valid&ready at a rising edge
i_cmd_write  input  1  1 = write, 0 = read
i_cmd_addr  input  ADDR_WIDTH  command address
i_cmd_data  input  DATA_WIDTH  write data
o_rsp_valid  output  1  read response valid
i_rsp_ready  input  1  response consumed when valid&ready
o_rsp_data  output  DATA_WIDTH  read data
o_err  output  1  one-cycle pulse: accepted command had addr >= DEPTH
i_clear  input  1  request clear sequence
o_busy  output  1  clear sequence in progress
o_clear_done  output  1  one-cycle pulse when a clear sequence finishes
o_mem_addr  output  ADDR_WIDTH  to SRAM i_addr
o_mem_write  output  1  to SRAM i_write
o_mem_data  output  DATA_WIDTH  to SRAM i_data
i_mem_data  input  DATA_WIDTH  from SRAM o_data

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0, FSM=IDLE, no read pending. After deassertion with INIT_ON_RESET=1, enter CLEAR on the first edge. In that first cycle o_cmd_ready=0 and o_busy=0.
- FSM states: IDLE, CLEAR, DONE.
- IDLE -> CLEAR when i_clear=1 and no read is pending. i_clear takes priority over a same-cycle command.
- CLEAR -> DONE after the write to DEPTH-1 is issued.
- DONE -> IDLE after one cycle. o_clear_done=1 in DONE only.
- o_cmd_ready = (state==IDLE) & !rd_pending & !i_clear. The combinational path from i_clear is permitted.
- SRAM port signals are registered. An accepted command at edge E0 drives o_mem_* during the cycle after E0.
- o_mem_write is 1 only for one cycle per accepted in-range write, or per clear step. It is otherwise 0.
- Writes: back-to-back accepted writes allowed, throughput 1 per cycle.
- Reads: accept at E0 sets rd_pending. The SRAM samples at E1. The controller captures i_mem_data into o_rsp_data at E2, and o_rsp_valid=1 from E2.
- o_rsp_valid and o_rsp_data hold until i_rsp_ready=1. rd_pending clears on the response handshake, so at most one read is outstanding. Read-to-valid latency is 2 cycles.
- Out-of-range address (addr >= DEPTH): o_err pulses 1 cycle after acceptance.
  - Write: dropped (o_mem_write stays 0).
  - Read: no SRAM access; response is CLEAR_VALUE with normal 2-cycle latency.
- Clear engine: counter from 0 to DEPTH-1, one write of CLEAR_VALUE per cycle, for exactly DEPTH write cycles.
  - o_busy=1 from CLEAR entry until DONE; it is 0 in DONE.
  - The counter stops at DEPTH-1 with no wrap, including when DEPTH=2**ADDR_WIDTH. Counter width is ADDR_WIDTH+1 internally.
  - i_clear while busy or in DONE is ignored, not queued.
- Reset mid-operation aborts everything: pending read dropped, response discarded, partial clear abandoned. The sequence restarts only per INIT_ON_RESET.
- o_mem_data and o_mem_addr may hold stale values when o_mem_write=0. Only o_mem_write qualifies a write.

Test Plan:
- Reset, INIT_ON_RESET=1, DEPTH=256, CLEAR_VALUE=8'h00 -> o_mem_write high for exactly 256 consecutive cycles, addrs 0..255; then o_clear_done pulses once; then o_cmd_ready=1.
- Write 8'hA5 to addr 3, next cycle read addr 3 with i_rsp_ready=1 -> o_rsp_valid exactly 2 cycles after the read accept with o_rsp_data=8'hA5; o_cmd_ready low until the response handshake.
- Read addr 3 with i_rsp_ready=0 for 5 cycles -> o_rsp_valid and data held stable for 5 cycles, o_cmd_ready=0 throughout; first i_rsp_ready cycle completes the response, and ready returns the next cycle.
- DEPTH=200: write addr 210, then read addr 210 -> o_err pulses for each; no o_mem_write; read returns CLEAR_VALUE.
- i_clear and i_cmd_valid high in the same IDLE cycle -> command not accepted, clear starts; i_clear re-pulsed mid-clear -> exactly one o_clear_done.
- i_rst_n asserted at clear step 100 -> outputs 0 immediately (asynchronous); after release, a fresh clear starts at addr 0.

Source files
------------

// File: rtl/sram_ctrl.sv
// Initiator-side controller for a single-port synchronous SRAM.
// Valid/ready command stream in, registered read responses out, plus a clear engine.
module sram_ctrl #(
    parameter int                    ADDR_WIDTH    = 8,
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    DEPTH         = 256,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0,
    parameter bit                    INIT_ON_RESET = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_err,
    input  logic                  i_clear,
    output logic                  o_busy,
    output logic                  o_clear_done,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_write,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    input  logic [DATA_WIDTH-1:0] i_mem_data
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_LAST  = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DONE
    } state_t;

    state_t                r_state;
    logic                  r_boot;
    logic [CW-1:0]         r_cnt;
    logic                  r_rd_pend;
    logic                  r_rd_s1;
    logic                  r_rd_s2;
    logic                  r_oor_s1;
    logic                  r_oor_s2;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_write;
    logic [DATA_WIDTH-1:0] r_mem_data;

    logic w_oor;
    logic w_ready;
    logic w_accept;

    assign w_oor    = {1'b0, i_cmd_addr} >= LP_DEPTH;
    // r_boot holds ready low for the first cycle after reset release
    assign w_ready  = (r_state == ST_IDLE) & ~r_boot & ~r_rd_pend & ~i_clear;
    assign w_accept = i_cmd_valid & w_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_boot      <= 1'b1;
            r_cnt       <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_s1     <= 1'b0;
            r_rd_s2     <= 1'b0;
            r_oor_s1    <= 1'b0;
            r_oor_s2    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_write <= 1'b0;
            r_mem_data  <= '0;
        end else begin
            r_mem_write <= 1'b0;
            r_err       <= 1'b0;
            r_boot      <= 1'b0;
            r_rd_s1     <= 1'b0;
            r_rd_s2     <= r_rd_s1;
            r_oor_s2    <= r_oor_s1;

            if (r_rd_s2) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= r_oor_s2 ? CLEAR_VALUE : i_mem_data;
            end else if (r_rsp_valid && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_rd_pend   <= 1'b0;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (r_boot) begin
                        if (INIT_ON_RESET) begin
                            r_state <= ST_CLEAR;
                            r_cnt   <= '0;
                        end
                    end else if (i_clear && !r_rd_pend) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                    end else if (w_accept) begin
                        r_err <= w_oor;
                        if (i_cmd_write) begin
                            if (!w_oor) begin
                                r_mem_write <= 1'b1;
                                r_mem_addr  <= i_cmd_addr;
                                r_mem_data  <= i_cmd_data;
                            end
                        end else begin
                            r_rd_pend <= 1'b1;
                            r_rd_s1   <= 1'b1;
                            r_oor_s1  <= w_oor;
                            if (!w_oor) begin
                                r_mem_addr <= i_cmd_addr;
                            end
                        end
                    end
                end
                ST_CLEAR: begin
                    r_mem_write <= 1'b1;
                    r_mem_addr  <= r_cnt[ADDR_WIDTH-1:0];
                    r_mem_data  <= CLEAR_VALUE;
                    // stop at the last cell; the extra counter bit avoids wrap at full depth
                    if (r_cnt == LP_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready  = w_ready;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_data   = r_rsp_data;
    assign o_err        = r_err;
    assign o_busy       = (r_state == ST_CLEAR);
    assign o_clear_done = (r_state == ST_DONE);
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_write  = r_mem_write;
    assign o_mem_data   = r_mem_data;

endmodule
